// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for pipeline stage registers.
//   skid_state_t : holding state of a skid-buffered stage
//   OCC_W        : width of the occupancy count
package pipe_pkg;
  localparam int OCC_W = 2;
  typedef enum logic [1:0] {S_EMPTY, S_BUSY, S_FULL} skid_state_t;
endpackage

// File: rtl/skid_data_reg.sv
// skid_data_reg: enable register with async active-low reset and sync clear.
//   clk, reset (async, active-low), i_clr (sync clear to RESET_VAL, wins over i_en),
//   i_en (load i_d), i_d / o_q (WIDTH-bit data)
module skid_data_reg #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) o_q <= RESET_VAL;
    else if (i_clr) o_q <= RESET_VAL;
    else if (i_en) o_q <= i_d;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline stage with valid/ready handshake and one-entry skid buffer.
//   clk, reset (async, active-low), flush (sync squash)
//   in_valid/in_ready/in_data   : upstream handshake, in_ready registered
//   out_valid/out_ready/out_data: downstream handshake, out_data from main register
//   occupancy                   : held entries (0..2)
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);
  skid_state_t r_state, w_next;
  logic w_in_xfer, w_out_xfer, w_main_en, w_skid_en;
  logic [WIDTH-1:0] w_main_d, w_skid_q;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= S_EMPTY;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (flush) w_next = S_EMPTY;
    else if (r_state == S_EMPTY) w_next = w_in_xfer ? S_BUSY : S_EMPTY;
    else if (r_state == S_BUSY) w_next = (w_in_xfer && !w_out_xfer) ? S_FULL :
                                         (!w_in_xfer && w_out_xfer) ? S_EMPTY : S_BUSY;
    else w_next = out_ready ? S_BUSY : S_FULL;
  end
  always_comb begin
    out_valid = r_state != S_EMPTY;
    in_ready  = r_state != S_FULL;
    occupancy = r_state == S_FULL ? OCC_W'(2) : r_state == S_BUSY ? OCC_W'(1) : '0;
  end
  // Skid only loads when a word arrives while the main entry is stuck;
  // draining always refills main from skid so order is preserved.
  always_comb begin
    w_skid_en = r_state == S_BUSY && w_in_xfer && !w_out_xfer;
    w_main_en = (r_state == S_EMPTY && w_in_xfer) ||
                (r_state == S_BUSY && w_in_xfer && w_out_xfer) ||
                (r_state == S_FULL && out_ready);
    w_main_d  = r_state == S_FULL ? w_skid_q : in_data;
  end
  skid_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk(clk), .reset(reset), .i_clr(flush), .i_en(w_main_en), .i_d(w_main_d), .o_q(out_data)
  );
  skid_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk(clk), .reset(reset), .i_clr(flush), .i_en(w_skid_en), .i_d(in_data), .o_q(w_skid_q)
  );
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed vector table, reset/flush sequences and random scoreboard.
module tb_pipe_skid_reg;
  logic clk = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [15:0] in_data = '0;
  logic in_ready, out_valid;
  logic [15:0] out_data;
  logic [1:0] occupancy;
  int checks = 0, errors = 0;

  pipe_skid_reg #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic iv; logic [15:0] d; logic ordy; logic fl;
    logic ov; logic ir; logic [1:0] occ; logic [15:0] od;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic iv, input logic [15:0] d, input logic ordy, input logic fl,
                     input logic ov, input logic ir, input logic [1:0] occ, input logic [15:0] od);
    tv.push_back('{iv, d, ordy, fl, ov, ir, occ, od});
  endtask

  function automatic logic [31:0] outs();
    return {12'h0, out_valid, in_ready, occupancy, out_data};
  endfunction

  logic [15:0] sb[$];
  logic [15:0] exp_d, held;
  logic ix, ox, hold;

  initial begin
    for (int i = 1; i <= 8; i++) add(1, 16'(i), 1, 0, 1, 1, 1, 16'(i));
    add(0, 16'h0000, 1, 0, 0, 1, 0, 16'h0008);
    add(1, 16'hAAAA, 0, 0, 1, 1, 1, 16'hAAAA);
    add(1, 16'hBBBB, 0, 0, 1, 0, 2, 16'hAAAA);
    for (int i = 0; i < 3; i++) add(1, 16'hCCCC, 0, 0, 1, 0, 2, 16'hAAAA);
    add(1, 16'hCCCC, 1, 0, 1, 1, 1, 16'hBBBB);
    add(1, 16'hCCCC, 1, 0, 1, 1, 1, 16'hCCCC);
    add(0, 16'h0000, 1, 0, 0, 1, 0, 16'hCCCC);
    add(1, 16'h1111, 0, 0, 1, 1, 1, 16'h1111);
    add(1, 16'h2222, 0, 0, 1, 0, 2, 16'h1111);
    add(1, 16'h3333, 0, 1, 0, 1, 0, 16'h0000);
    add(0, 16'h0000, 1, 0, 0, 1, 0, 16'h0000);
    add(1, 16'h4444, 0, 0, 1, 1, 1, 16'h4444);
    add(1, 16'h5555, 1, 1, 0, 1, 0, 16'h0000);
    add(1, 16'h6666, 1, 0, 1, 1, 1, 16'h6666);
    add(0, 16'h0000, 1, 0, 0, 1, 0, 16'h6666);
    add(1, 16'h7777, 1, 1, 0, 1, 0, 16'h0000);

    #12;
    chk("reset_state", outs(), {12'h0, 1'b0, 1'b1, 2'd0, 16'h0000});
    @(posedge clk); #1;
    reset = 1;
    step();
    chk("after_reset_release", outs(), {12'h0, 1'b0, 1'b1, 2'd0, 16'h0000});

    foreach (tv[i]) begin
      in_valid = tv[i].iv; in_data = tv[i].d; out_ready = tv[i].ordy; flush = tv[i].fl;
      step();
      chk($sformatf("vec%0d", i), outs(), {12'h0, tv[i].ov, tv[i].ir, tv[i].occ, tv[i].od});
    end
    flush = 0;

    in_valid = 1; in_data = 16'hA0A0; out_ready = 0;
    step();
    in_data = 16'hB0B0;
    step();
    chk("prereset_full", outs(), {12'h0, 1'b1, 1'b0, 2'd2, 16'hA0A0});
    #2 reset = 0;
    #1 chk("async_reset", outs(), {12'h0, 1'b0, 1'b1, 2'd0, 16'h0000});
    in_valid = 0;
    step();
    reset = 1;
    out_ready = 1;
    step();
    chk("post_reset_empty", outs(), {12'h0, 1'b0, 1'b1, 2'd0, 16'h0000});

    for (int c = 0; c < 10000; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data = 16'($urandom);
      ix = in_valid & in_ready;
      ox = out_valid & out_ready;
      hold = out_valid & !out_ready;
      held = out_data;
      if (ox) begin
        exp_d = sb.size() > 0 ? sb.pop_front() : 16'hDEAD;
        chk("rand_order", {16'h0, out_data}, {16'h0, exp_d});
      end
      if (ix) sb.push_back(in_data);
      step();
      if (hold) chk("rand_stable", {16'h0, out_data}, {16'h0, held});
      chk("rand_state", {29'h0, out_valid, in_ready, 1'b0} | {30'h0, occupancy},
          {29'h0, sb.size() > 0, sb.size() < 2, 1'b0} | 32'(sb.size()));
    end
    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      if (out_valid) begin
        exp_d = sb.size() > 0 ? sb.pop_front() : 16'hDEAD;
        chk("drain_order", {16'h0, out_data}, {16'h0, exp_d});
      end
      step();
    end
    chk("drain_empty", {31'h0, out_valid} | 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with a valid/ready handshake and a one-entry skid buffer. It replaces bare load-enabled stage registers between CPU pipeline stages. It sustains one transfer per cycle while keeping `in_ready` fully registered, so no combinational path runs from downstream stall to upstream. It also supports a synchronous flush for branch/exception squash.

## Interface
- `WIDTH`, 16: payload width in bits (≥1).
- `RESET_VAL`, 0: value of both data registers after reset or flush (WIDTH bits).

- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset. Asserted at 0, takes effect immediately, released synchronously by the surrounding reset tree.
- `flush` in 1: synchronous squash, active-high.
- `in_valid` in 1: upstream has data.
- `in_ready` out 1: stage accepts data; registered.
- `in_data` in WIDTH: upstream payload.
- `out_valid` out 1: `out_data` is valid; registered.
- `out_ready` in 1: downstream accepts.
- `out_data` out WIDTH: payload; driven directly from the main register.
- `occupancy` out 2: number of held entries (0, 1 or 2).

## Operation
- Handshakes:
  - Input transfer is `in_valid & in_ready`.
  - Output transfer is `out_valid & out_ready`.
  - `in_valid` may be asserted regardless of `in_ready`.
  - Once `out_valid` is asserted, `out_data` stays stable until an output transfer or flush.
- States (one-hot or binary, implementation choice):
  - **S_EMPTY**: `out_valid`=0, `in_ready`=1, `occupancy`=0.
  - **S_BUSY**: `out_valid`=1, `in_ready`=1, `occupancy`=1.
  - **S_FULL**: `out_valid`=1, `in_ready`=0, `occupancy`=2.
- Transitions, when `flush`=0:
  - S_EMPTY, in transfer: main←`in_data`, go to S_BUSY. No in transfer: stay.
  - S_BUSY, in and out transfer: main←`in_data`, stay.
  - S_BUSY, in transfer only: skid←`in_data`, go to S_FULL.
  - S_BUSY, out transfer only: go to S_EMPTY.
  - S_BUSY, neither: hold.
  - S_FULL, `out_ready`=1: main←skid, go to S_BUSY. `in_valid` is ignored because `in_ready`=0.
  - S_FULL, `out_ready`=0: hold.
- Flush:
  - Highest priority over all transitions.
  - Next state is S_EMPTY; main and skid are set to `RESET_VAL`.
  - An input transfer in the flush cycle is discarded, and an output transfer in the flush cycle still completes.
- Reset: state is S_EMPTY, main = skid = `RESET_VAL`. Outputs: `out_valid`=0, `in_ready`=1, `out_data`=`RESET_VAL`, `occupancy`=0.
- Order is preserved: data leaves in acceptance order, and the skid entry is never bypassed.

## Timing
- Latency: 1 cycle. Data accepted at edge N appears on `out_data` with `out_valid`=1 after edge N.
- Throughput: 1 transfer/cycle in S_BUSY with both sides active.
- `in_ready` deasserts on the edge after the first stalled acceptance. The skid absorbs that one in-flight word, so no data is lost.
- `in_ready`, `out_valid`, `out_data` and `occupancy` are pure register outputs, with no input-to-output combinational path.
- Reset asserted mid-operation: outputs go to their reset values asynchronously, without waiting for a clock edge, and held data is lost.

## Structure
- Shared package `pipe_pkg`: `skid_state_t` enum {S_EMPTY, S_BUSY, S_FULL} and the occupancy width constant `OCC_W = 2`.
- Sub-module `skid_data_reg`: WIDTH-parametrised enable register with asynchronous active-low reset to `RESET_VAL` and synchronous clear. Instantiate it twice, once for main and once for skid.
- The FSM and enable/select logic live in `pipe_skid_reg`.

## Test plan
- **Reset:** assert `reset`=0 mid-stream with `WIDTH`=16, `RESET_VAL`=16'h0000 → immediately `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_data`=16'h0000.
- **Streaming:** `out_ready`=1, push 16'h0001…16'h0008 on consecutive cycles → same sequence on `out_data` one cycle later, `in_ready` constantly 1.
- **Stall:** push 16'hAAAA then 16'hBBBB with `out_ready`=0 → `occupancy`=2 and `in_ready`=0. Hold `in_valid` with 16'hCCCC for 3 cycles → no acceptance. Release `out_ready` → outputs AAAA, BBBB, CCCC in order.
- **Flush:** in S_FULL with `in_valid`=1, pulse `flush` → next cycle `out_valid`=0, `occupancy`=0, `out_data`=`RESET_VAL`. The input from the flush cycle is never output.
- **Randomized check:** random `in_valid`/`out_ready` for 10k cycles → scoreboard shows no loss, duplication or reorder, and `out_data` stays stable while `out_valid & !out_ready`.
